fir_ntap_pipe: RTL and testbench



---
 rtl/fir_ntap_pipe.sv | 145 ++++++++++++++
 tb/tb_fir_ntap_pipe.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fir_ntap_pipe.sv
// fir_ntap_pipe: parametrised N-tap direct-form FIR with programmable
// per-tap coefficients, valid-qualified input and a balanced adder tree.
// Optional macro FIR_PIPE_EN registers the products and every tree level
// (latency LOG2T+2); without it the tree is combinational (latency 1).
// Results are identical in both builds.

// One tap product, sign- or zero-extended to the full output width so the
// tree can add at a single width without ever overflowing.
module fir_tap_mul #(
    parameter int W      = 16,
    parameter int CW     = 16,
    parameter int OW     = 35,
    parameter int SIGNED = 0
) (
    input  logic [W-1:0]  x,
    input  logic [CW-1:0] c,
    output logic [OW-1:0] p
);
    localparam int PW = W + CW;

    generate
        if (SIGNED != 0) begin : g_sgn
            logic signed [PW-1:0] xe, ce, pr;
            assign xe = $signed({{CW{x[W-1]}}, x});
            assign ce = $signed({{W{c[CW-1]}}, c});
            assign pr = xe * ce;
            assign p  = {{(OW-PW){pr[PW-1]}}, pr};
        end else begin : g_uns
            logic [PW-1:0] pr;
            assign pr = {{CW{1'b0}}, x} * {{W{1'b0}}, c};
            assign p  = {{(OW-PW){1'b0}}, pr};
        end
    endgenerate
endmodule

module fir_ntap_pipe #(
    parameter int W      = 16,
    parameter int CW     = 16,
    parameter int TAPS   = 8,
    parameter int SIGNED = 0,
    parameter int LOG2T  = $clog2(TAPS),
    parameter int OW     = W + CW + LOG2T
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [W-1:0]     a,
    input  logic             in_valid,
    input  logic             coef_we,
    input  logic [LOG2T-1:0] coef_addr,
    input  logic [CW-1:0]    coef_data,
    output logic [OW-1:0]    s,
    output logic             out_valid
);
`ifdef FIR_PIPE_EN
    localparam int STAGES = LOG2T + 2;
`else
    localparam int STAGES = 1;
`endif

    logic [TAPS-1:0][W-1:0]             x;
    logic [TAPS-1:0][CW-1:0]            c;
    logic [TAPS-1:0][OW-1:0]            prod;
    logic [LOG2T:0][TAPS-1:0][OW-1:0]   tree_d;
    logic [OW-1:0]                      result;
    logic [STAGES:0]                    vld_pipe;
    logic                               unused_tree;

    // Delay line: shifts only on accepted samples, holds through gaps
    always_ff @(posedge clk) begin
        if (reset)
            x <= '0;
        else if (in_valid)
            x <= {x[TAPS-2:0], a};
    end

    // Coefficient bank: unit weights after reset, i.e. a moving sum
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < TAPS; k++)
                c[k] <= CW'(1);
        end else if (coef_we) begin
            c[coef_addr] <= coef_data;
        end
    end

    for (genvar k = 0; k < TAPS; k++) begin : g_tap
        fir_tap_mul #(.W(W), .CW(CW), .OW(OW), .SIGNED(SIGNED)) u_mul (
            .x (x[k]),
            .c (c[k]),
            .p (prod[k])
        );
    end

`ifdef FIR_PIPE_EN
    logic [LOG2T:0][TAPS-1:0][OW-1:0] tree_q;

    // Each level sums pairs of the previous level's registers
    always_comb begin
        tree_d    = '0;
        tree_d[0] = prod;
        for (int l = 1; l <= LOG2T; l++)
            for (int j = 0; j < TAPS/2; j++)
                if (j < (TAPS >> l))
                    tree_d[l][j] = tree_q[l-1][2*j] + tree_q[l-1][2*j+1];
    end

    // Product and tree registers; they run freely, the valid pipe marks data
    always_ff @(posedge clk) begin
        if (reset)
            tree_q <= '0;
        else
            tree_q <= tree_d;
    end

    assign result      = tree_q[LOG2T][0];
    assign unused_tree = ^tree_q;
`else
    // Whole tree in one combinational cone from x[] and c[]
    always_comb begin
        tree_d    = '0;
        tree_d[0] = prod;
        for (int l = 1; l <= LOG2T; l++)
            for (int j = 0; j < TAPS/2; j++)
                if (j < (TAPS >> l))
                    tree_d[l][j] = tree_d[l-1][2*j] + tree_d[l-1][2*j+1];
    end

    assign result      = tree_d[LOG2T][0];
    assign unused_tree = ^tree_d;
`endif

    // Valid shift register and output register; s holds between results
    always_ff @(posedge clk) begin
        if (reset) begin
            vld_pipe <= '0;
            s        <= '0;
        end else begin
            vld_pipe <= {vld_pipe[STAGES-1:0], in_valid};
            if (vld_pipe[STAGES-1])
                s <= result;
        end
    end

    assign out_valid = vld_pipe[STAGES];
endmodule

// File: tb/tb_fir_ntap_pipe.sv
// Self-checking bench for fir_ntap_pipe: an unsigned and a signed instance
// share one stimulus stream and are compared every cycle against a
// sample-history / dot-product reference model.
module tb_fir_ntap_pipe;
`ifdef FIR_PIPE_EN
    localparam int LAT = 5;
`else
    localparam int LAT = 1;
`endif
    localparam int OW = 35;

    logic          clk, reset, in_valid, coef_we;
    logic [15:0]   a, coef_data;
    logic [2:0]    coef_addr;
    logic [OW-1:0] s_u, s_s;
    logic          ov_u, ov_s;

    fir_ntap_pipe #(.SIGNED(0)) u_dut (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .s(s_u), .out_valid(ov_u)
    );

    fir_ntap_pipe #(.SIGNED(1)) u_dut_s (
        .clk(clk), .reset(reset), .a(a), .in_valid(in_valid),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .s(s_s), .out_valid(ov_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct { int due; longint vu; longint vs; } res_t;

    logic [15:0] hist [8];
    logic [15:0] cf   [8];
    res_t        pend [$];
    longint      hold_u, hold_s;
    logic [63:0] cap_u [$];
    int          cyc, n_tests, n_fail;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [63:0] tr(input longint v);
        logic [63:0] t;
        t = v;
        return {29'b0, t[OW-1:0]};
    endfunction

    // Reference: apply what the DUT saw at this edge
    task automatic model_edge();
        longint vu, vs;
        cyc++;
        if (reset) begin
            for (int k = 0; k < 8; k++) begin hist[k] = '0; cf[k] = 16'd1; end
            pend.delete();
            hold_u = 0;
            hold_s = 0;
        end else begin
            if (coef_we) cf[coef_addr] = coef_data;
            if (in_valid) begin
                for (int k = 7; k > 0; k--) hist[k] = hist[k-1];
                hist[0] = a;
                vu = 0;
                vs = 0;
                for (int k = 0; k < 8; k++) begin
                    vu += longint'(hist[k]) * longint'(cf[k]);
                    vs += longint'($signed(hist[k])) * longint'($signed(cf[k]));
                end
                pend.push_back('{cyc + LAT, vu, vs});
            end
        end
    endtask

    task automatic check();
        logic exp_ov;
        exp_ov = 1'b0;
        if (pend.size() > 0 && pend[0].due == cyc) begin
            exp_ov = 1'b1;
            hold_u = pend[0].vu;
            hold_s = pend[0].vs;
            pend.delete(0);
        end
        chk("ov_u", {63'b0, ov_u}, {63'b0, exp_ov});
        chk("s_u", {29'b0, s_u}, tr(hold_u));
        chk("ov_s", {63'b0, ov_s}, {63'b0, exp_ov});
        chk("s_s", {29'b0, s_s}, tr(hold_s));
        if (ov_u) cap_u.push_back({29'b0, s_u});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
        check();
    endtask

    task automatic drive(input logic v, input logic [15:0] d);
        in_valid = v;
        a        = d;
        tick();
    endtask

    task automatic drain();
        in_valid = 1'b0;
        repeat (LAT + 2) tick();
    endtask

    initial begin
        int pat [7];
        n_tests = 0; n_fail = 0; cyc = 0;
        reset = 1'b1; in_valid = 1'b0; a = '0;
        coef_we = 1'b0; coef_addr = '0; coef_data = '0;
        repeat (2) tick();
        chk("rst_ov", {63'b0, ov_u}, 64'd0);
        chk("rst_s", {29'b0, s_u}, 64'd0);
        reset = 1'b0;
        tick();

        // Moving sum of a full-scale constant
        cap_u.delete();
        for (int i = 0; i < 10; i++) drive(1'b1, 16'hFFFF);
        drain();
        chk("ramp_cnt", cap_u.size(), 64'd10);
        for (int i = 0; i < cap_u.size() && i < 10; i++)
            chk("ramp_val", cap_u[i], 64'd65535 * ((i < 8) ? i + 1 : 8));
        chk("ramp_settle", {29'b0, s_u}, 64'd524280);

        // c[k]=k+1 while flushing with zeros, then an impulse
        for (int k = 0; k < 8; k++) begin
            coef_we = 1'b1; coef_addr = 3'(k); coef_data = 16'(k + 1);
            drive(1'b1, 16'd0);
        end
        coef_we = 1'b0;
        drain();
        cap_u.delete();
        drive(1'b1, 16'd1);
        for (int i = 0; i < 7; i++) drive(1'b1, 16'd0);
        drain();
        chk("imp_cnt", cap_u.size(), 64'd8);
        for (int i = 0; i < cap_u.size() && i < 8; i++)
            chk("imp_val", cap_u[i], 64'(i + 1));

        // Gapped input pattern
        pat = '{1, 0, 0, 1, 1, 0, 1};
        for (int i = 0; i < 7; i++) drive(pat[i] != 0, 16'($urandom));
        drain();

        // All coefficients -1, most negative sample
        for (int k = 0; k < 8; k++) begin
            coef_we = 1'b1; coef_addr = 3'(k); coef_data = 16'hFFFF;
            in_valid = 1'b0;
            tick();
        end
        coef_we = 1'b0;
        for (int i = 0; i < 8; i++) drive(1'b1, 16'h8000);
        drain();
        chk("sgn_settle", {29'b0, s_s}, 64'd262144);

        // Coefficient write on the same edge as a sample
        reset = 1'b1; in_valid = 1'b0; tick();
        reset = 1'b0;
        cap_u.delete();
        drive(1'b1, 16'd2);
        drive(1'b1, 16'd2);
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd3;
        drive(1'b1, 16'd5);
        coef_we = 1'b0;
        drive(1'b1, 16'd0);
        drain();
        chk("cw_cnt", cap_u.size(), 64'd4);
        if (cap_u.size() == 4) begin
            chk("cw_r0", cap_u[0], 64'd2);
            chk("cw_r1", cap_u[1], 64'd4);
            chk("cw_r2", cap_u[2], 64'd19);
            chk("cw_r3", cap_u[3], 64'd9);
        end

        // Reset with results in flight, coefficient write ignored in reset
        for (int i = 0; i < 3; i++) drive(1'b1, 16'($urandom));
        in_valid = 1'b0; reset = 1'b1;
        coef_we = 1'b1; coef_addr = 3'd0; coef_data = 16'd9;
        tick();
        reset = 1'b0; coef_we = 1'b0;
        cap_u.delete();
        drain();
        chk("rst_nopulse", cap_u.size(), 64'd0);
        chk("rst_s0", {29'b0, s_u}, 64'd0);
        drive(1'b1, 16'd7);
        drain();
        chk("post_rst", {29'b0, s_u}, 64'd7);

        // Random traffic with random coefficient writes
        for (int i = 0; i < 300; i++) begin
            coef_we   = ($urandom_range(7) == 0);
            coef_addr = 3'($urandom);
            coef_data = 16'($urandom);
            drive($urandom_range(3) != 0, 16'($urandom));
        end
        coef_we = 1'b0;
        drain();
        chk("rand_drained", pend.size(), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
